// File: rtl/udm_cpu_mem_arbiter.sv
// Two-master (CPU data port / UART debug master) arbiter onto one memory port.
// Round-robin between masters, grant held through memory stalls, at most one read in flight.
module udm_cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_be_i,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
    output logic                    cpu_ack_o,
    output logic                    cpu_resp_o,
    output logic [DATA_WIDTH-1:0]   cpu_rdata_o,

    input  logic                    udm_req_i,
    input  logic                    udm_we_i,
    input  logic [ADDR_WIDTH-1:0]   udm_addr_i,
    input  logic [DATA_WIDTH/8-1:0] udm_be_i,
    input  logic [DATA_WIDTH-1:0]   udm_wdata_i,
    output logic                    udm_ack_o,
    output logic                    udm_resp_o,
    output logic [DATA_WIDTH-1:0]   udm_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic                    mem_resp_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    dbg_wait_resp_o
);

    // Handshake: a master holds req and payload stable until its ack; ack is
    // mem_ack_i routed to the granted master; resp pulses once per accepted read.
    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_RESP = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   lock_q, lock_d;
    logic   lock_udm_q, lock_udm_d;
    logic   owner_udm_q, owner_udm_d;
    logic   last_udm_q, last_udm_d;
    logic   gnt_cpu, gnt_udm;
    logic   resp_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            lock_q      <= 1'b0;
            lock_udm_q  <= 1'b0;
            owner_udm_q <= 1'b0;
            last_udm_q  <= 1'b1;   // "UDM served last" so the CPU wins the first tie
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            lock_udm_q  <= lock_udm_d;
            owner_udm_q <= owner_udm_d;
            last_udm_q  <= last_udm_d;
        end
    end

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_udm = 1'b0;
        if (!rst_i && state_q == ST_IDLE) begin
            if (lock_q) begin
                gnt_cpu = !lock_udm_q && cpu_req_i;
                gnt_udm = lock_udm_q && udm_req_i;
            end else if (cpu_req_i && udm_req_i) begin
                gnt_cpu = last_udm_q;
                gnt_udm = !last_udm_q;
            end else begin
                gnt_cpu = cpu_req_i;
                gnt_udm = udm_req_i;
            end
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (gnt_cpu) begin
            mem_req_o   = 1'b1;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_be_o    = cpu_be_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (gnt_udm) begin
            mem_req_o   = 1'b1;
            mem_we_o    = udm_we_i;
            mem_addr_o  = udm_addr_i;
            mem_be_o    = udm_be_i;
            mem_wdata_o = udm_wdata_i;
        end
    end

    assign cpu_ack_o       = gnt_cpu && mem_ack_i;
    assign udm_ack_o       = gnt_udm && mem_ack_i;
    assign resp_valid      = !rst_i && state_q == ST_WAIT_RESP && mem_resp_i;
    assign cpu_resp_o      = resp_valid && !owner_udm_q;
    assign udm_resp_o      = resp_valid && owner_udm_q;
    assign cpu_rdata_o     = cpu_resp_o ? mem_rdata_i : '0;
    assign udm_rdata_o     = udm_resp_o ? mem_rdata_i : '0;
    assign dbg_wait_resp_o = !rst_i && state_q == ST_WAIT_RESP;

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        lock_udm_d  = lock_udm_q;
        owner_udm_d = owner_udm_q;
        last_udm_d  = last_udm_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_o && mem_ack_i) begin
                    last_udm_d = gnt_udm;
                    lock_d     = 1'b0;
                    if (!mem_we_o) begin
                        state_d     = ST_WAIT_RESP;
                        owner_udm_d = gnt_udm;
                    end
                end else if (mem_req_o) begin
                    lock_d     = 1'b1;
                    lock_udm_d = gnt_udm;
                end
            end
            ST_WAIT_RESP: begin
                if (mem_resp_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_udm_cpu_mem_arbiter.sv
// Bench for udm_cpu_mem_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level model of who owns the memory port.
module tb_udm_cpu_mem_arbiter;

    typedef logic [138:0] vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
    logic [3:0]  cpu_be_i = '0;
    logic        udm_req_i = 1'b0, udm_we_i = 1'b0;
    logic [31:0] udm_addr_i = '0, udm_wdata_i = '0;
    logic [3:0]  udm_be_i = '0;
    logic        mem_ack_i = 1'b0, mem_resp_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        cpu_ack_o, cpu_resp_o, udm_ack_o, udm_resp_o;
    logic [31:0] cpu_rdata_o, udm_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        dbg_wait_resp_o;

    udm_cpu_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_be_i(cpu_be_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_ack_o(cpu_ack_o), .cpu_resp_o(cpu_resp_o), .cpu_rdata_o(cpu_rdata_o),
        .udm_req_i(udm_req_i), .udm_we_i(udm_we_i), .udm_addr_i(udm_addr_i),
        .udm_be_i(udm_be_i), .udm_wdata_i(udm_wdata_i),
        .udm_ack_o(udm_ack_o), .udm_resp_o(udm_resp_o), .udm_rdata_o(udm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_resp_i(mem_resp_i), .mem_rdata_i(mem_rdata_i),
        .dbg_wait_resp_o(dbg_wait_resp_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: which master holds the port. pending_read = master whose
    // read awaits data (-1 none); held_by = master stalled by memory (-1 none);
    // last_served = master whose transfer was accepted most recently.
    int pending_read = -1;
    int held_by      = -1;
    int last_served  = 1;
    bit acked_cpu, acked_udm, was_rst;

    function automatic int exp_grant();
        if (rst_i || pending_read != -1) return -1;
        if (held_by == 0) return cpu_req_i ? 0 : -1;
        if (held_by == 1) return udm_req_i ? 1 : -1;
        if (cpu_req_i && udm_req_i) return (last_served == 0) ? 1 : 0;
        if (cpu_req_i) return 0;
        if (udm_req_i) return 1;
        return -1;
    endfunction

    function automatic vec_t exp_vec();
        int   g = exp_grant();
        logic mreq = 1'b0, mwe = 1'b0;
        logic [31:0] ma = '0, mw = '0, cr = '0, ur = '0;
        logic [3:0]  mb = '0;
        logic ca, ua, cr_v, ur_v, busy;
        if (g == 0) begin
            mreq = 1'b1; mwe = cpu_we_i; ma = cpu_addr_i; mb = cpu_be_i; mw = cpu_wdata_i;
        end else if (g == 1) begin
            mreq = 1'b1; mwe = udm_we_i; ma = udm_addr_i; mb = udm_be_i; mw = udm_wdata_i;
        end
        ca   = (g == 0) && mem_ack_i;
        ua   = (g == 1) && mem_ack_i;
        busy = !rst_i && pending_read != -1;
        cr_v = busy && mem_resp_i && pending_read == 0;
        ur_v = busy && mem_resp_i && pending_read == 1;
        if (cr_v) cr = mem_rdata_i;
        if (ur_v) ur = mem_rdata_i;
        return {mreq, mwe, ma, mb, mw, ca, cr_v, cr, ua, ur_v, ur, busy};
    endfunction

    function automatic vec_t act_vec();
        return {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                cpu_ack_o, cpu_resp_o, cpu_rdata_o,
                udm_ack_o, udm_resp_o, udm_rdata_o, dbg_wait_resp_o};
    endfunction

    task automatic tick();
        int   g;
        logic we;
        @(posedge clk_i);
        g  = exp_grant();
        we = (g == 1) ? udm_we_i : cpu_we_i;
        acked_cpu = (g == 0) && mem_ack_i;
        acked_udm = (g == 1) && mem_ack_i;
        was_rst   = rst_i;
        if (rst_i) begin
            pending_read = -1; held_by = -1; last_served = 1;
        end else if (pending_read != -1) begin
            if (mem_resp_i) pending_read = -1;
        end else if (g != -1) begin
            if (mem_ack_i) begin
                last_served = g;
                held_by     = -1;
                if (!we) pending_read = g;
            end else begin
                held_by = g;
            end
        end
    endtask

    task automatic cpu_drive(input logic r, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d);
        cpu_req_i = r; cpu_we_i = w; cpu_addr_i = a; cpu_be_i = b; cpu_wdata_i = d;
    endtask

    task automatic udm_drive(input logic r, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d);
        udm_req_i = r; udm_we_i = w; udm_addr_i = a; udm_be_i = b; udm_wdata_i = d;
    endtask

    task automatic mem_drive(input logic a, input logic r, input logic [31:0] d);
        mem_ack_i = a; mem_resp_i = r; mem_rdata_i = d;
    endtask

    task automatic test_reset();
        vec_t e, a;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            rst_i = 1'b1;
            cpu_drive(1, 0, 32'h4, 4'hF, 32'h1);
            udm_drive(1, 1, 32'h8, 4'hF, 32'h2);
            mem_drive(1, 1, 32'h55);
            #1;
            e = exp_vec(); a = act_vec();
            checks++;
            if (a !== e || a !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h want %h", a, e);
            end
            tick();
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        cpu_drive(0, 0, 0, 0, 0); udm_drive(0, 0, 0, 0, 0); mem_drive(0, 0, 0);
        #1;
        checks++;
        if (act_vec() !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %h want 0", act_vec());
        end
        tick();
    endtask

    task automatic test_cpu_write();
        @(negedge clk_i);
        cpu_drive(1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        mem_drive(1, 0, 0);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || mem_addr_o !== 32'h10 || mem_wdata_o !== 32'hDEADBEEF
            || mem_be_o !== 4'hF || mem_we_o !== 1'b1 || cpu_ack_o !== 1'b1 || udm_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL cpu_write: got %h want %h", act_vec(), exp_vec());
        end
        tick();
        @(negedge clk_i);
        cpu_drive(0, 0, 0, 0, 0); mem_drive(0, 0, 0);
        #1;
        checks++;
        if (dbg_wait_resp_o !== 1'b0 || act_vec() !== '0) begin
            errors++;
            $display("FAIL cpu_write_idle: got %h want 0", act_vec());
        end
        tick();
    endtask

    task automatic test_both_reads();
        @(negedge clk_i); rst_i = 1'b1; tick();
        @(negedge clk_i);
        rst_i = 1'b0;
        cpu_drive(1, 0, 32'h100, 4'hF, 0);
        udm_drive(1, 0, 32'h200, 4'h3, 0);
        mem_drive(1, 0, 0);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || cpu_ack_o !== 1'b1 || udm_ack_o !== 1'b0 || mem_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL both_reads_cpu_first: got %h want %h", act_vec(), exp_vec());
        end
        tick();
        @(negedge clk_i);
        cpu_drive(0, 0, 0, 0, 0);
        mem_drive(0, 1, 32'h12345678);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || cpu_resp_o !== 1'b1 || cpu_rdata_o !== 32'h12345678
            || udm_resp_o !== 1'b0 || udm_rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL both_reads_cpu_resp: got %h want %h", act_vec(), exp_vec());
        end
        tick();
        @(negedge clk_i);
        mem_drive(1, 0, 0);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || udm_ack_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_be_o !== 4'h3) begin
            errors++;
            $display("FAIL both_reads_udm_next: got %h want %h", act_vec(), exp_vec());
        end
        tick();
        @(negedge clk_i);
        udm_drive(0, 0, 0, 0, 0);
        mem_drive(0, 1, 32'hCAFEF00D);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || udm_resp_o !== 1'b1 || udm_rdata_o !== 32'hCAFEF00D || cpu_resp_o !== 1'b0) begin
            errors++;
            $display("FAIL both_reads_udm_resp: got %h want %h", act_vec(), exp_vec());
        end
        tick();
        @(negedge clk_i); mem_drive(0, 0, 0); tick();
    endtask

    task automatic test_lock_stall();
        // A CPU-only accept first, so the pointer would favour UDM on a tie.
        @(negedge clk_i);
        cpu_drive(1, 1, 32'h20, 4'hF, 32'h1111);
        mem_drive(1, 0, 0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            cpu_drive(1, 1, 32'h30, 4'hF, 32'h3333);
            if (c >= 2) udm_drive(1, 1, 32'h40, 4'hF, 32'h4444);
            mem_drive(c == 4, 0, 0);
            #1;
            checks++;
            if (act_vec() !== exp_vec() || mem_addr_o !== 32'h30 || udm_ack_o !== 1'b0
                || cpu_ack_o !== (c == 4)) begin
                errors++;
                $display("FAIL lock_stall_c%0d: got %h want %h", c, act_vec(), exp_vec());
            end
            tick();
        end
        @(negedge clk_i);
        cpu_drive(0, 0, 0, 0, 0);
        mem_drive(1, 0, 0);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || udm_ack_o !== 1'b1 || mem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL lock_stall_udm_after: got %h want %h", act_vec(), exp_vec());
        end
        tick();
        @(negedge clk_i); udm_drive(0, 0, 0, 0, 0); mem_drive(0, 0, 0); tick();
    endtask

    task automatic test_back_to_back();
        int n_cpu = 0, n_udm = 0;
        logic [31:0] ca = 32'h1000, ua = 32'h2000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            cpu_drive(1, 1, ca, 4'hF, ca ^ 32'hA0A0_0000);
            udm_drive(1, 1, ua, 4'hC, ua ^ 32'h0B0B_0000);
            mem_drive(1, 0, 0);
            #1;
            checks++;
            if (act_vec() !== exp_vec() || cpu_ack_o !== (k % 2 == 0) || udm_ack_o !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL back_to_back_k%0d: got %h want %h", k, act_vec(), exp_vec());
            end
            if (cpu_ack_o) begin n_cpu++; ca = ca + 4; end
            if (udm_ack_o) begin n_udm++; ua = ua + 4; end
            tick();
        end
        checks++;
        if (n_cpu != 4 || n_udm != 4) begin
            errors++;
            $display("FAIL back_to_back_counts: got cpu=%0d udm=%0d want 4/4", n_cpu, n_udm);
        end
        @(negedge clk_i);
        cpu_drive(0, 0, 0, 0, 0); udm_drive(0, 0, 0, 0, 0); mem_drive(0, 0, 0);
        tick();
    endtask

    task automatic test_reset_abandon();
        @(negedge clk_i);
        cpu_drive(1, 0, 32'h50, 4'hF, 0);
        mem_drive(1, 0, 0);
        tick();
        @(negedge clk_i);
        cpu_drive(0, 0, 0, 0, 0);
        mem_drive(0, 0, 0);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || dbg_wait_resp_o !== 1'b1) begin
            errors++;
            $display("FAIL abandon_wait: got %h want %h", act_vec(), exp_vec());
        end
        rst_i = 1'b1;
        tick();
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_drive(0, 1, 32'hA5A5A5A5);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || act_vec() !== '0) begin
            errors++;
            $display("FAIL abandon_resp_ignored: got %h want 0", act_vec());
        end
        tick();
    endtask

    task automatic test_stray_resp();
        @(negedge clk_i);
        cpu_drive(0, 0, 0, 0, 0); udm_drive(0, 0, 0, 0, 0);
        mem_drive(0, 1, 32'h77778888);
        #1;
        checks++;
        if (act_vec() !== exp_vec() || cpu_resp_o !== 1'b0 || udm_resp_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_resp: got %h want %h", act_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            @(negedge clk_i);
            rst_i = ($urandom_range(0, 60) == 0);
            if (!cpu_req_i || acked_cpu || was_rst) begin
                if ($urandom_range(0, 1) == 1)
                    cpu_drive(1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom);
                else
                    cpu_drive(0, 0, 0, 0, 0);
            end
            if (!udm_req_i || acked_udm || was_rst) begin
                if ($urandom_range(0, 1) == 1)
                    udm_drive(1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom);
                else
                    udm_drive(0, 0, 0, 0, 0);
            end
            mem_drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom);
            #1;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_n%0d: got %h want %h", n, act_vec(), exp_vec());
            end
            tick();
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        cpu_drive(0, 0, 0, 0, 0); udm_drive(0, 0, 0, 0, 0); mem_drive(0, 0, 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_both_reads();
        test_lock_stall();
        test_back_to_back();
        test_reset_abandon();
        test_stray_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
